score_text_writer: RTL and testbench

SCORE_TEXT_WRITER -- requirements
Module: score_text_writer

---
 rtl/score_text_writer.sv | 186 ++++++++++++++++++
 tb/tb_score_text_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_text_writer.sv
// Score-to-text writer: saturates a binary score to 999999, converts it to six
// BCD digits by shift-and-add-3, and writes the glyphs into the text VRAM one byte at a time.
module score_text_writer #(
    parameter int CHAR_BASE  = 228,
    parameter bit LEAD_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] score,
    input  logic        score_valid,
    input  logic        wr_wait,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    output logic        busy,
    output logic        done
);

    // state    | meaning
    // IDLE     | waiting for score_valid
    // CONVERT  | 20 shift-and-add-3 steps, one input bit per cycle
    // WRITE    | one VRAM byte write per digit, most-significant first
    // FINISH   | one-cycle done pulse, then IDLE or the pending update
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    localparam logic [19:0] SCORE_MAX = 20'd999999;
    localparam logic [12:0] BASE      = 13'(CHAR_BASE);
    localparam logic [2:0]  LAST_DIG  = 3'd5;
    localparam logic [2:0]  NUM_DIG   = 3'd6;
    localparam logic [4:0]  LAST_BIT  = 5'd19;

    state_t      state;
    logic        armed;
    logic [19:0] bin_sr;
    logic [23:0] bcd;
    logic [4:0]  bit_cnt;
    logic [2:0]  digit_idx;
    logic        nonzero_seen;
    logic        pend_valid;
    logic [19:0] pend_score;

    logic [3:0]  cur_digit;
    logic [12:0] char_idx;
    logic [1:0]  lane;
    logic        blank;
    logic [7:0]  glyph;
    logic        strobe;
    logic        accepted;

    function automatic logic [19:0] saturate(input logic [19:0] s);
        return (s > SCORE_MAX) ? SCORE_MAX : s;
    endfunction

    function automatic logic [23:0] bcd_step(input logic [23:0] b, input logic in_bit);
        logic [23:0] t;
        t = b;
        for (int i = 0; i < 6; i++) begin
            if (t[4*i +: 4] >= 4'd5)
                t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        end
        return {t[22:0], in_bit};
    endfunction

    always_comb begin
        cur_digit = 4'd0;
        case (digit_idx)
            3'd0:    cur_digit = bcd[23:20];
            3'd1:    cur_digit = bcd[19:16];
            3'd2:    cur_digit = bcd[15:12];
            3'd3:    cur_digit = bcd[11:8];
            3'd4:    cur_digit = bcd[7:4];
            3'd5:    cur_digit = bcd[3:0];
            default: cur_digit = 4'd0;
        endcase
    end

    assign char_idx = BASE + {10'd0, digit_idx};
    assign lane     = char_idx[1:0];
    // The units digit is always shown so a zero score still reads "0".
    assign blank    = LEAD_BLANK && !nonzero_seen && (cur_digit == 4'd0) && (digit_idx != LAST_DIG);
    assign glyph    = blank ? 8'h20 : {4'h3, cur_digit};
    assign strobe   = score_valid && armed;
    assign accepted = wr_en && !wr_wait;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            armed        <= 1'b0;
            bin_sr       <= 20'd0;
            bcd          <= 24'd0;
            bit_cnt      <= 5'd0;
            digit_idx    <= 3'd0;
            nonzero_seen <= 1'b0;
            pend_valid   <= 1'b0;
            pend_score   <= 20'd0;
            wr_en        <= 1'b0;
            wr_addr      <= 11'd0;
            wr_data      <= 32'd0;
            wr_be        <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Blocks a strobe coinciding with the first edge after reset release.
            armed <= 1'b1;

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (strobe) begin
                        bin_sr  <= saturate(score);
                        bcd     <= 24'd0;
                        bit_cnt <= LAST_BIT;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end

                CONVERT: begin
                    if (strobe) begin
                        pend_valid <= 1'b1;
                        pend_score <= saturate(score);
                    end
                    bcd    <= bcd_step(bcd, bin_sr[19]);
                    bin_sr <= {bin_sr[18:0], 1'b0};
                    if (bit_cnt == 5'd0) begin
                        digit_idx    <= 3'd0;
                        nonzero_seen <= 1'b0;
                        state        <= WRITE;
                    end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end
                end

                WRITE: begin
                    if (strobe) begin
                        pend_valid <= 1'b1;
                        pend_score <= saturate(score);
                    end
                    // digit_idx names the next digit to present; outputs hold during a stall.
                    if (!wr_en || accepted) begin
                        if (digit_idx == NUM_DIG) begin
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            wr_en        <= 1'b1;
                            wr_addr      <= char_idx[12:2];
                            wr_be        <= 4'b0001 << lane;
                            wr_data      <= {24'd0, glyph} << {lane, 3'b000};
                            nonzero_seen <= nonzero_seen || (cur_digit != 4'd0);
                            digit_idx    <= digit_idx + 3'd1;
                        end
                    end
                end

                FINISH: begin
                    done <= 1'b0;
                    if (strobe || pend_valid) begin
                        bin_sr     <= strobe ? saturate(score) : pend_score;
                        bcd        <= 24'd0;
                        bit_cnt    <= LAST_BIT;
                        pend_valid <= 1'b0;
                        state      <= CONVERT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_text_writer.sv
// Bench for score_text_writer: table of scores with expected glyph strings feeding a
// write scoreboard, plus timed sequences for stalls, pending updates and reset.
module tb_score_text_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] score = 20'd0;
    logic        score_valid = 1'b0;
    logic        wr_wait = 1'b0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        busy;
    logic        done;

    score_text_writer #(.CHAR_BASE(228), .LEAD_BLANK(1'b1)) dut (
        .clk(clk), .reset(reset), .score(score), .score_valid(score_valid),
        .wr_wait(wr_wait), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .busy(busy), .done(done)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [10:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [19:0] score;
        logic [47:0] glyphs;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_glyphs(input logic [47:0] g);
        for (int i = 0; i < 6; i++) begin
            int  c;
            wr_t w;
            c      = 228 + i;
            w.addr = 11'(c / 4);
            w.be   = 4'(1 << (c % 4));
            w.data = 32'(g[47 - 8*i -: 8]) << (8 * (c % 4));
            exp_q.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (wr_en && !wr_wait) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 48'(wr_addr), 48'h7ff_ffff);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", 48'(wr_addr), 48'(mon_e.addr));
                    check("wr_be",   48'(wr_be),   48'(mon_e.be));
                    check("wr_data", 48'(wr_data), 48'(mon_e.data));
                end
            end
        end
    end

    // Strobe one score, then watch 60 cycles counted from the sampling edge.
    task automatic run_timed(input logic [19:0] s, input int stall_at, input int stall_len,
                             input int exp_first, input int exp_done);
        int          first, n_en, done_at;
        logic [47:0] held;
        first = -1; n_en = 0; done_at = -1; held = '0;
        @(posedge clk); #1;
        score = s; score_valid = 1'b1;
        @(posedge clk); #1;
        score_valid = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            wr_wait = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
            @(negedge clk);
            if (wr_en) begin
                if (first < 0) first = cyc;
                n_en++;
            end
            if (done && done_at < 0) done_at = cyc;
            if (stall_len > 0 && cyc == stall_at) held = 48'({wr_addr, wr_be, wr_data});
            if (stall_len > 0 && cyc > stall_at && cyc < stall_at + stall_len)
                check("stall_hold", 48'({wr_addr, wr_be, wr_data}), held);
            @(posedge clk); #1;
        end
        wr_wait = 1'b0;
        check("first_wr_cycle", 48'(first), 48'(exp_first));
        check("done_cycle", 48'(done_at), 48'(exp_done));
        check("wr_en_cycles", 48'(n_en), 48'(6 + stall_len));
        check("queue_drained", 48'(exp_q.size()), 48'd0);
    endtask

    initial begin
        int d0, d1, busy_low, ndone, seen_wr, seen_busy;

        vecs[0] = '{20'd0,       48'h202020202030};
        vecs[1] = '{20'd1234,    48'h202031323334};
        vecs[2] = '{20'd1048575, 48'h393939393939};
        vecs[3] = '{20'd999999,  48'h393939393939};
        vecs[4] = '{20'd1000000, 48'h393939393939};
        vecs[5] = '{20'd100000,  48'h313030303030};
        vecs[6] = '{20'd7,       48'h202020202037};
        vecs[7] = '{20'd500500,  48'h353030353030};
        vecs[8] = '{20'd10,      48'h202020203130};
        vecs[9] = '{20'd90,      48'h202020203930};

        #25;
        check("rst_wr_en",   48'(wr_en),   48'd0);
        check("rst_wr_addr", 48'(wr_addr), 48'd0);
        check("rst_wr_data", 48'(wr_data), 48'd0);
        check("rst_wr_be",   48'(wr_be),   48'd0);
        check("rst_busy",    48'(busy),    48'd0);
        check("rst_done",    48'(done),    48'd0);
        @(negedge clk); reset = 1'b0;
        repeat (3) @(posedge clk);

        foreach (vecs[k]) begin
            push_glyphs(vecs[k].glyphs);
            run_timed(vecs[k].score, 0, 0, 21, 27);
        end

        // Five-cycle stall while the third digit is presented.
        push_glyphs(48'h363534333231);
        run_timed(20'd654321, 23, 5, 21, 32);

        // Three strobes during one conversion of 50: only 50 and 300 are written.
        push_glyphs(48'h202020203530);
        push_glyphs(48'h202020333030);
        d0 = -1; d1 = -1; busy_low = 0; ndone = 0;
        @(posedge clk); #1; score = 20'd50; score_valid = 1'b1;
        @(posedge clk); #1; score_valid = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc == 3 || cyc == 8 || cyc == 24) begin
                score = (cyc == 3) ? 20'd100 : (cyc == 8) ? 20'd200 : 20'd300;
                score_valid = 1'b1;
            end else begin
                score_valid = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                ndone++;
                if (d0 < 0) d0 = cyc; else if (d1 < 0) d1 = cyc;
            end
            if (!busy && cyc < 55) busy_low++;
            @(posedge clk); #1;
        end
        score_valid = 1'b0;
        check("pend_done0", 48'(d0), 48'd27);
        check("pend_done1", 48'(d1), 48'd55);
        check("pend_ndone", 48'(ndone), 48'd2);
        check("pend_busy_gap", 48'(busy_low), 48'd0);
        check("pend_queue", 48'(exp_q.size()), 48'd0);

        // Strobe landing in the FINISH cycle starts straight away.
        push_glyphs(48'h202020202035);
        push_glyphs(48'h202020203432);
        d0 = -1; d1 = -1;
        @(posedge clk); #1; score = 20'd5; score_valid = 1'b1;
        @(posedge clk); #1; score_valid = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (d0 < 0) begin
                    d0 = cyc;
                    score = 20'd42; score_valid = 1'b1;
                end else if (d1 < 0) begin
                    d1 = cyc;
                end
            end
            @(posedge clk); #1;
            score_valid = 1'b0;
        end
        check("fin_done0", 48'(d0), 48'd27);
        check("fin_done1", 48'(d1), 48'd55);
        check("fin_queue", 48'(exp_q.size()), 48'd0);

        // Reset during the third write, with an update pending.
        push_glyphs(48'h313233343536);
        @(posedge clk); #1; score = 20'd123456; score_valid = 1'b1;
        @(posedge clk); #1; score_valid = 1'b0;
        for (int cyc = 0; cyc < 23; cyc++) begin
            score_valid = (cyc == 5);
            score = 20'd777;
            @(posedge clk); #1;
        end
        score_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_wr_en",   48'(wr_en),   48'd0);
        check("mid_rst_wr_addr", 48'(wr_addr), 48'd0);
        check("mid_rst_wr_data", 48'(wr_data), 48'd0);
        check("mid_rst_wr_be",   48'(wr_be),   48'd0);
        check("mid_rst_busy",    48'(busy),    48'd0);
        check("mid_rst_done",    48'(done),    48'd0);
        check("writes_before_rst", 48'(exp_q.size()), 48'd4);
        exp_q.delete();
        @(negedge clk); reset = 1'b0;
        seen_wr = 0; seen_busy = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (wr_en) seen_wr++;
            if (busy) seen_busy++;
        end
        check("post_rst_writes", 48'(seen_wr), 48'd0);
        check("post_rst_busy", 48'(seen_busy), 48'd0);

        push_glyphs(48'h202020203432);
        run_timed(20'd42, 0, 0, 21, 27);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
